// File: rtl/io_cmd_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters' commands onto the io Avalon port.
// Latency: request sampled in IDLE at N -> io_we at N+1; io_done at M -> ack at M+1 (4-cycle minimum turnaround).
// Backpressure: requesters hold req level until their ack; a single transaction is in flight, io_done timeout forces completion.
module io_cmd_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255,
    parameter int TO_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  io_we,
    output logic [DATA_WIDTH-1:0] io_writedata,
    input  logic [DATA_WIDTH-1:0] io_readdata,
    input  logic                  io_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Terminal count of the WAIT counter; reaching it forces an error completion.
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] wr_q, wr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [TO_BITS-1:0]    cnt_q, cnt_d;
    logic                  win;

    // State and datapath registers; synchronous reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            wr_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout detection in WAIT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to whoever did not win last; a lone requester always wins.
                    win     = (req0 && req1) ? ~last_q : req1;
                    grant_d = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    wr_d    = win ? wdata1 : wdata0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Saturate at the terminal value so the counter can never wrap.
                cnt_d = (cnt_q == TO_LAST) ? cnt_q : cnt_q + 1'b1;
                if (io_done) begin
                    // io_done takes priority over a simultaneous timeout.
                    rdata_d = io_readdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = 2'b00;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                err_d   = 1'b0;
            end
        endcase
    end

    assign io_we        = (state_q == ST_ISSUE);
    assign io_writedata = wr_q;
    assign busy         = (state_q != ST_IDLE);
    assign ack0         = (state_q == ST_RESP) && grant_q[0];
    assign ack1         = (state_q == ST_RESP) && grant_q[1];
    assign grant        = grant_q;
    assign rdata        = rdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_io_cmd_arbiter.sv
// Self-checking bench for io_cmd_arbiter with a transaction-level reference model.
// Latency: one check point per cycle of interest, sampled 1 time unit after the rising edge.
// Backpressure: requesters hold req until ack; io_done timing is chosen per transaction.
module tb_io_cmd_arbiter;

    localparam int DW      = 64;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err, busy, io_we, io_done;
    logic [DW-1:0] rdata, io_writedata, io_readdata;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    // Reference model state: round-robin pointer and last response word.
    bit            model_last;
    logic [DW-1:0] model_rdata;

    io_cmd_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .TO_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .grant(grant), .busy(busy),
        .io_we(io_we), .io_writedata(io_writedata),
        .io_readdata(io_readdata), .io_done(io_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full transaction from an observed IDLE cycle (requests already driven)
    // to the following IDLE cycle. dly = cycles after io_we at which io_done is
    // pulsed; outside 1..TIMEOUT means io_done never comes.
    task automatic run_txn(input int dly, input logic [DW-1:0] rd, input bit hold, input bit drop_we);
        bit            who;
        bit            exp_err;
        bit            quiet_bad;
        int            exp_k;
        logic [DW-1:0] exp_wd;
        who    = (req0 && req1) ? !model_last : req1;
        exp_wd = who ? wdata1 : wdata0;
        tick();
        // ISSUE cycle
        chk("issue_we", 64'(io_we), 64'(1));
        chk("issue_wdata", io_writedata, exp_wd);
        chk("issue_grant", 64'(grant), who ? 64'(2) : 64'(1));
        chk("issue_busy", 64'(busy), 64'(1));
        if (drop_we) begin
            if (who) req1 = 1'b0; else req0 = 1'b0;
        end
        io_done     = 1'($urandom_range(0, 1));
        io_readdata = rnd64();
        exp_err   = !(dly >= 1 && dly <= TIMEOUT);
        exp_k     = exp_err ? TIMEOUT : dly;
        quiet_bad = 1'b0;
        for (int k = 1; k <= exp_k; k++) begin
            tick();
            if (ack0 || ack1 || io_we || !busy) quiet_bad = 1'b1;
            io_done     = (k == dly);
            io_readdata = (k == dly) ? rd : rnd64();
        end
        chk("wait_quiet", 64'(quiet_bad), 64'(0));
        tick();
        // RESP cycle
        io_done     = 1'($urandom_range(0, 1));
        io_readdata = rnd64();
        chk("resp_ack_win", who ? 64'(ack1) : 64'(ack0), 64'(1));
        chk("resp_ack_other", who ? 64'(ack0) : 64'(ack1), 64'(0));
        chk("resp_err", 64'(err), 64'(exp_err));
        chk("resp_rdata", rdata, exp_err ? '0 : rd);
        chk("resp_we", 64'(io_we), 64'(0));
        model_rdata = exp_err ? '0 : rd;
        model_last  = who;
        if (!hold) begin
            if (who) req1 = 1'b0; else req0 = 1'b0;
        end
        tick();
        // IDLE cycle
        io_done = 1'b0;
        chk("idle_grant", 64'(grant), 64'(0));
        chk("idle_err", 64'(err), 64'(0));
        chk("idle_ack", 64'(ack0 | ack1), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_last  = 1'b1;
        model_rdata = '0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        wdata0 = '0; wdata1 = '0; io_done = 1'b0; io_readdata = '0;

        // Reset values
        do_reset();
        chk("rst_ack0", 64'(ack0), 64'(0));
        chk("rst_ack1", 64'(ack1), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_we", 64'(io_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_rdata", rdata, '0);
        chk("rst_wdata", io_writedata, '0);

        // Single requester 0, io_done 3 cycles after io_we
        req0 = 1'b1; wdata0 = 64'h0000_0000_0000_00A1;
        run_txn(3, 64'h0000_0000_0000_0F0F, 1'b0, 1'b0);

        // Both held from reset: strict alternation over 8 transactions
        req0 = 1'b1; req1 = 1'b1;
        wdata0 = rnd64(); wdata1 = rnd64();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("rr_alternate", 64'(!model_last), 64'(i % 2));
            run_txn(2, rnd64(), 1'b1, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Timeout on requester 1, then a normal transaction
        req1 = 1'b1; wdata1 = rnd64();
        run_txn(0, '0, 1'b0, 1'b0);
        req0 = 1'b1; wdata0 = rnd64();
        run_txn(4, rnd64(), 1'b0, 1'b0);

        // Stray io_done in IDLE
        io_done = 1'b1; io_readdata = rnd64();
        tick();
        io_done = 1'b0;
        chk("stray_busy", 64'(busy), 64'(0));
        chk("stray_grant", 64'(grant), 64'(0));
        chk("stray_ack", 64'(ack0 | ack1), 64'(0));
        tick();
        chk("stray_busy2", 64'(busy), 64'(0));
        chk("stray_rdata", rdata, model_rdata);

        // io_done coincident with the terminal timeout cycle
        req0 = 1'b1; wdata0 = rnd64();
        run_txn(TIMEOUT, rnd64(), 1'b0, 1'b0);

        // Reset during WAIT
        req0 = 1'b1; wdata0 = rnd64();
        tick();
        chk("abort_issue_we", 64'(io_we), 64'(1));
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_grant", 64'(grant), 64'(0));
        chk("abort_ack0", 64'(ack0), 64'(0));
        chk("abort_we", 64'(io_we), 64'(0));
        chk("abort_wdata", io_writedata, '0);
        rst = 1'b0;
        model_last  = 1'b1;
        model_rdata = '0;
        // Fresh command with new wdata0; req0 drops right after io_we, req1 pending
        wdata0 = rnd64(); req1 = 1'b1; wdata1 = rnd64();
        run_txn(3, rnd64(), 1'b0, 1'b1);
        run_txn(2, rnd64(), 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(1, 3);
            if (r[0]) req0 = 1'b1;
            if (r[1]) req1 = 1'b1;
            wdata0 = rnd64(); wdata1 = rnd64();
            run_txn($urandom_range(1, 12), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_cmd_arbiter.md
Name: io_cmd_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the io Avalon interface (joystick/button input controller).
- Requester 0 is the HPS bridge; requester 1 is the on-chip game/robot FSM.
- Serialises 64-bit opcode-encoded commands: issues a one-cycle write strobe downstream, waits for the done pulse, returns readdata to the winner, and flags a timeout if done never arrives.

Parameters:
DATA_WIDTH, 64, width of command/read data words
TIMEOUT, 255, max cycles in WAIT before forced error completion (1..2^TO_BITS-1)
TO_BITS, 8, width of timeout counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 request, level, held until ack0
wdata0  input  DATA_WIDTH  requester 0 command word (opcode in [3:0]), stable while req0
req1  input  1  requester 1 request, level, held until ack1
wdata1  input  DATA_WIDTH  requester 1 command word
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
rdata  output  DATA_WIDTH  response data, valid in ack cycle, held until next ack
err  output  1  valid with ack: 1 = timeout completion
grant  output  2  one-hot owner of current transaction, 00 when idle
busy  output  1  high in any state other than IDLE
io_we  output  1  write strobe to io interface, one cycle per transaction
io_writedata  output  DATA_WIDTH  command word to io interface
io_readdata  input  DATA_WIDTH  read data from io interface
io_done  input  1  completion pulse from io interface

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state updates on rising clk.
- Reset values:
  - ack0 = ack1 = err = io_we = busy = 0
  - grant = 00, rdata = 0, io_writedata = 0
  - state = IDLE, last-grant pointer = 1 (so requester 0 wins the first tie), timeout counter = 0
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, select the winner. Round-robin: on a tie, grant the requester other than last-grant; a single requester wins unconditionally.
  - Latch the winner's wdata into io_writedata, set grant one-hot, update last-grant, go to ISSUE.
- ISSUE:
  - io_we = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - io_we = 0; counter increments every cycle.
  - If io_done = 1: latch io_readdata into rdata, set err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: rdata = 0, err = 1, go to RESP.
  - io_done and timeout reached in the same cycle: io_done wins (err = 0).
- RESP:
  - The ack for the granted requester pulses for 1 cycle, and err is presented in the same cycle.
  - Next cycle: grant = 00, err returns to 0, go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N: io_we at N+1.
  - io_done at cycle M (≥ N+2): ack at M+1.
  - Minimum turnaround is 4 cycles per transaction.
- Requester rules:
  - The arbiter samples wdata only in the IDLE grant cycle.
  - Deasserting req before ack does not abort an issued transaction; ack is still pulsed.
  - A req high in the cycle after its own ack (IDLE) is treated as a new request.
- io_done is ignored in IDLE, ISSUE and RESP (stray pulses cause no state change).
- rst asserted mid-transaction: return to IDLE with reset values next edge. No ack is generated and io_we never re-fires for the aborted command.
- Timeout counter never wraps: it saturates at the terminal compare.

Test Plan:
- req0 only, wdata0=64'h0000_0000_0000_00A1; io_done pulsed 3 cycles after io_we with io_readdata=64'h0000_0000_0000_0F0F -> io_we one cycle with io_writedata=...A1, ack0 one cycle later, rdata=...0F0F, err=0, grant=01 then 00.
- req0 and req1 both held high from reset, io_done returned 2 cycles after each io_we -> grants alternate 01,10,01,10; ack0/ack1 alternate; no starvation over 8 transactions.
- req1 only, io_done never asserted, TIMEOUT=255 -> ack1 exactly 256 cycles after io_we (255 in WAIT plus RESP), err=1, rdata=0; next request proceeds normally.
- io_done pulse while in IDLE, plus io_done coincident with the terminal timeout cycle -> no state change from the idle pulse; the coincident case completes with err=0 and rdata=io_readdata.
- rst asserted during WAIT of a req0 transaction -> next cycle busy=0, grant=00, no ack0; after rst release with req0 still high, a fresh io_we with the current wdata0.
- req0 dropped in the cycle after io_we -> ack0 still pulsed on io_done, and the arbiter then grants a pending req1.
